// File: rtl/mod_mul.sv
// Sequential modular multiplier: outC = (a * b) mod p, MSB-first shift-add-reduce, one bit of b per clock.
// Optional macro MOD_MUL_DONE_PULSE_EN adds a one-cycle 'done' output pulse on every published result.
module mod_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             opselect,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] outC,
  output logic             rdy,
`ifdef MOD_MUL_DONE_PULSE_EN
  output logic             err,
  output logic             done
`else
  output logic             err
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int EW = WIDTH + 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           stateReg, stateNext;
  logic [WIDTH-1:0] aReg, aNext;
  logic [WIDTH-1:0] bReg, bNext;
  logic [WIDTH-1:0] pReg, pNext;
  logic [WIDTH-1:0] accReg, accNext;
  logic [CW-1:0]    cntReg, cntNext;
  logic [WIDTH-1:0] outCReg, outCNext;
  logic             errReg, errNext;
`ifdef MOD_MUL_DONE_PULSE_EN
  logic             doneReg, doneNext;
`endif

  logic             bBit;
  logic [WIDTH-1:0] addend;
  logic [EW-1:0]    pEx;
  logic [EW-1:0]    tSum;
  logic [EW-1:0]    tRed1;
  logic [WIDTH-1:0] tRed2;
  logic             startLegal;

  // Current multiplier bit gates the multiplicand into the accumulator step.
  assign bBit = bReg[cntReg];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_addend
      assign addend[gi] = aReg[gi] & bBit;
    end
  endgenerate

  // Two extra bits hold 2R + a (< 3p) even when p is close to 2^WIDTH.
  assign pEx   = {2'b00, pReg};
  assign tSum  = {1'b0, accReg, 1'b0} + {2'b00, addend};
  assign tRed1 = (tSum >= pEx) ? (tSum - pEx) : tSum;
  assign tRed2 = WIDTH'((tRed1 >= pEx) ? (tRed1 - pEx) : tRed1);

  assign startLegal = (p >= WIDTH'(2)) && (a < p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      pReg     <= '0;
      accReg   <= '0;
      cntReg   <= '0;
      outCReg  <= '0;
      errReg   <= 1'b0;
`ifdef MOD_MUL_DONE_PULSE_EN
      doneReg  <= 1'b0;
`endif
    end else begin
      stateReg <= stateNext;
      aReg     <= aNext;
      bReg     <= bNext;
      pReg     <= pNext;
      accReg   <= accNext;
      cntReg   <= cntNext;
      outCReg  <= outCNext;
      errReg   <= errNext;
`ifdef MOD_MUL_DONE_PULSE_EN
      doneReg  <= doneNext;
`endif
    end
  end

  always_comb begin
    stateNext = stateReg;
    aNext     = aReg;
    bNext     = bReg;
    pNext     = pReg;
    accNext   = accReg;
    cntNext   = cntReg;
    outCNext  = outCReg;
    errNext   = errReg;
`ifdef MOD_MUL_DONE_PULSE_EN
    doneNext  = 1'b0;
`endif
    unique case (stateReg)
      IDLE: begin
        if (opselect) begin
          if (!startLegal) begin
            // Rejected start publishes a zero result and stays idle.
            outCNext = '0;
            errNext  = 1'b1;
`ifdef MOD_MUL_DONE_PULSE_EN
            doneNext = 1'b1;
`endif
          end else begin
            aNext     = a;
            bNext     = b;
            pNext     = p;
            accNext   = '0;
            cntNext   = CW'(WIDTH - 1);
            errNext   = 1'b0;
            stateNext = RUN;
          end
        end
      end
      RUN: begin
        accNext = tRed2;
        if (cntReg == '0) begin
          outCNext  = tRed2;
          stateNext = IDLE;
`ifdef MOD_MUL_DONE_PULSE_EN
          doneNext  = 1'b1;
`endif
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign outC = outCReg;
  assign rdy  = (stateReg == IDLE);
  assign err  = errReg;
`ifdef MOD_MUL_DONE_PULSE_EN
  assign done = doneReg;
`endif

endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul (WIDTH=32): directed vector table plus hand-written handshake/reset sequences.
module tb_mod_mul;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         opselect = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] p = '0;
  logic [W-1:0] outC;
  logic         rdy;
  logic         err;
`ifdef MOD_MUL_DONE_PULSE_EN
  logic         done;
`endif

  mod_mul #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opselect (opselect),
    .a        (a),
    .b        (b),
    .p        (p),
    .outC     (outC),
    .rdy      (rdy),
`ifdef MOD_MUL_DONE_PULSE_EN
    .err      (err),
    .done     (done)
`else
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic [W-1:0] expOut;
    logic         expErr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic startOp(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vp);
    @(negedge clk);
    a = va;
    b = vb;
    p = vp;
    opselect = 1'b1;
    @(posedge clk);
    #1;
    opselect = 1'b0;
  endtask

  // Counts edges until rdy is seen high; bounded so a stuck design still reaches the summary.
  task automatic waitDone(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) break;
    end
  endtask

  task automatic checkDonePulse(input string name);
`ifdef MOD_MUL_DONE_PULSE_EN
    chk({name, " done high"}, W'(done), W'(1));
    @(posedge clk);
    #1;
    chk({name, " done low after"}, W'(done), W'(0));
`else
    if (name.len() == 0) $display("empty name");
`endif
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{32'd7, 32'd2, 32'd13, 32'd1, 1'b0};
    vecs[1]  = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'd1, 1'b0};
    vecs[2]  = '{32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFB,
                 32'((64'h12345678 * 64'h9ABCDEF0) % 64'hFFFFFFFB), 1'b0};
    vecs[3]  = '{32'd15, 32'd3, 32'd13, 32'd0, 1'b1};
    vecs[4]  = '{32'd0, 32'd3, 32'd1, 32'd0, 1'b1};
    vecs[5]  = '{32'd3, 32'd5, 32'd7, 32'd1, 1'b0};
    vecs[6]  = '{32'd5, 32'd0, 32'd11, 32'd0, 1'b0};
    vecs[7]  = '{32'd0, 32'd123, 32'd11, 32'd0, 1'b0};
    vecs[8]  = '{32'd4, 32'd100, 32'd7, 32'd1, 1'b0};
    vecs[9]  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 1'b0};
    vecs[10] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{32'd1, 32'd1, 32'd0, 32'd0, 1'b1};

    // Reset state while rst_n is held low.
    #12;
    chk("reset outC", outC, W'(0));
    chk("reset rdy", W'(rdy), W'(1));
    chk("reset err", W'(err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle rdy", W'(rdy), W'(1));
`ifdef MOD_MUL_DONE_PULSE_EN
    chk("idle no done", W'(done), W'(0));
`endif

    for (int i = 0; i < 12; i++) begin
      startOp(vecs[i].a, vecs[i].b, vecs[i].p);
      if (vecs[i].expErr) begin
        chk($sformatf("vec%0d rdy stays", i), W'(rdy), W'(1));
        chk($sformatf("vec%0d err", i), W'(err), W'(1));
        chk($sformatf("vec%0d outC", i), outC, vecs[i].expOut);
        checkDonePulse($sformatf("vec%0d", i));
        chk($sformatf("vec%0d rdy later", i), W'(rdy), W'(1));
      end else begin
        chk($sformatf("vec%0d rdy low", i), W'(rdy), W'(0));
        waitDone(cyc);
        chk($sformatf("vec%0d latency", i), W'(cyc), W'(32));
        chk($sformatf("vec%0d outC", i), outC, vecs[i].expOut);
        chk($sformatf("vec%0d err", i), W'(err), W'(0));
        checkDonePulse($sformatf("vec%0d", i));
      end
    end

    // opselect held high: inputs change during RUN, second op starts on first idle edge.
    @(negedge clk);
    a = 32'd5;
    b = 32'd6;
    p = 32'd11;
    opselect = 1'b1;
    @(posedge clk);
    #1;
    chk("hold rdy low", W'(rdy), W'(0));
    @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    p = 32'd3;
    waitDone(cyc);
    chk("hold first latency", W'(cyc), W'(32));
    chk("hold first outC", outC, W'(8));
`ifdef MOD_MUL_DONE_PULSE_EN
    chk("hold first done", W'(done), W'(1));
`endif
    @(posedge clk);
    #1;
    chk("hold restart rdy low", W'(rdy), W'(0));
    opselect = 1'b0;
    waitDone(cyc);
    chk("hold second latency", W'(cyc), W'(32));
    chk("hold second outC", outC, W'(1));

    // Asynchronous reset during RUN cycle 10.
    startOp(32'd7, 32'd2, 32'd13);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort outC", outC, W'(0));
    chk("abort rdy", W'(rdy), W'(1));
    chk("abort err", W'(err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    startOp(32'd5, 32'd6, 32'd11);
    chk("post-reset rdy low", W'(rdy), W'(0));
    waitDone(cyc);
    chk("post-reset latency", W'(cyc), W'(32));
    chk("post-reset outC", outC, W'(8));
    checkDonePulse("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mod_mul.md
Name: mod_mul

Overview:
- Sequential modular multiplier: computes outC = (a * b) mod p using MSB-first interleaved shift-add-reduce, one bit of b per clock.
- Forward-direction companion to the binary-EEA inverter in the ALU. It consumes the inverter's outputs (x * k^-1 mod p) and checks them (k * k^-1 mod p == 1).
- Uses the same opselect/rdy start-done handshake as the other ALU arithmetic units, so one controller can drive both.

Parameters:
- WIDTH, 32: operand/modulus/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opselect  input  1  start request; sampled only while idle.
- a  input  WIDTH  multiplicand; must satisfy a < p.
- b  input  WIDTH  multiplier; any value.
- p  input  WIDTH  modulus; must satisfy p >= 2.
- outC  output  WIDTH  result (a*b) mod p; holds until next accepted start.
- rdy  output  1  high when idle and able to accept a start; low while computing.
- err  output  1  high when the last start request had an illegal operand.

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n). Values while rst_n low:
  - state=IDLE, outC=0, rdy=1, err=0, accumulator R=0, bit counter=0.
  - Reset asserted mid-operation aborts the computation immediately; no partial result is published.
- States: IDLE, RUN.
- IDLE, opselect=1 at rising edge N:
  - If p < 2 or a >= p: outC<=0, err<=1, rdy stays 1, remain IDLE (error takes one edge).
  - Otherwise: latch a, b, p into internal registers; R<=0; cnt<=WIDTH-1; err<=0; rdy<=0; go to RUN.
- RUN, each edge (i = cnt):
  - t = 2*R + (b_latched[i] ? a_latched : 0), computed in WIDTH+2 bits; t <= 3p-3 by invariant.
  - t1 = (t >= p) ? t-p : t; t2 = (t1 >= p) ? t1-p : t1; R <= t2. Invariant: R < p after every step.
  - cnt != 0: cnt<=cnt-1, stay RUN.
  - cnt == 0: outC<=t2, rdy<=1, go to IDLE.
- Latency: accepted at edge N; result valid and rdy=1 after edge N+WIDTH. Exactly WIDTH RUN cycles, independent of data.
- Back-to-back: opselect high at edge N+WIDTH+1 (rdy=1) starts the next operation; no dead cycle is required beyond that.
- opselect is ignored while in RUN; holding it high through a computation does not restart it. If it is still high after completion, the next edge starts a new operation with the current inputs.
- Inputs a, b, p may change freely during RUN; only the latched copies are used.
- Edge values: b=0 -> outC=0. a=0 -> outC=0. b >= p is legal (reduction is inherent). p = 2^WIDTH-1 must work without overflow, hence the WIDTH+2-bit datapath.
- err is sticky until the next accepted (legal) start or reset. outC is never X after reset.

Optional Feature:
- Macro: MOD_MUL_DONE_PULSE_EN.
- Defined: adds output port done (1 bit, reset 0). done is high for exactly one cycle after the edge that publishes a result: either RUN completion or an error rejection.
- Undefined: no done port. Completion is observable only via the rdy rising edge or the err rising edge. All other behaviour is identical.

Test Plan:
- WIDTH=32, p=13, a=7, b=2, one-cycle opselect -> rdy low next cycle; exactly 32 cycles later outC=1, rdy=1, err=0.
- p=0xFFFFFFFB, a=0xFFFFFFFA, b=0xFFFFFFFA -> outC=1 (i.e. (-1)^2); also a=0x12345678, b=0x9ABCDEF0, same p -> outC equals the reference model (a*b)%p.
- a=15, p=13 (a >= p), and separately p=1 -> err=1, outC=0, rdy never drops; a following legal start (a=3, b=5, p=7) -> err=0, outC=1.
- opselect held high for 40 cycles with a=5, b=6, p=11 -> first result outC=8 after 32 RUN cycles; input changes during RUN ignored; second operation starts on the first idle edge.
- Assert rst_n low at RUN cycle 10 -> outC=0, rdy=1, err=0 immediately (asynchronously); a subsequent start runs the full 32 cycles correctly.
- With MOD_MUL_DONE_PULSE_EN: done is high exactly one cycle, coincident with the rdy rise or the err set; zero pulses while idle without a start.
